// File: rtl/alu_pipe_mc_if.sv
// ============================================================================
// Module      : alu_pipe_mc_if
// Description : Operand-issue and result-return handshake bundle for alu_pipe_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, result_hi, carry_out, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, result_hi, carry_out, overflow, zero, negative
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe_mc.sv
// ============================================================================
// Module      : alu_pipe_mc
// Description : Handshaked ALU, registered result stage, shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe_mc #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_pipe_mc_if.slave  bus
);

  localparam int             CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

  localparam logic [2:0] c_op_add  = 3'd0;
  localparam logic [2:0] c_op_sub  = 3'd1;
  localparam logic [2:0] c_op_and  = 3'd2;
  localparam logic [2:0] c_op_or   = 3'd3;
  localparam logic [2:0] c_op_xor  = 3'd4;
  localparam logic [2:0] c_op_nota = 3'd5;
  localparam logic [2:0] c_op_shl  = 3'd6;
  localparam logic [2:0] c_op_mul  = 3'd7;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [2*WIDTH-1:0] r_acc;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry_out;
  logic               r_overflow;
  logic               r_zero;
  logic               r_negative;

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_accept_mul;
  logic               w_mul_last;
  logic               w_mul_done;
  logic               w_mul_step;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  assign w_out_free   = !r_out_valid || bus.out_ready;
  assign w_in_ready   = (r_state == IDLE) && w_out_free;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_accept_mul = w_accept && (bus.op == c_op_mul);

  // The last multiply step is only taken once the output register can take the product.
  assign w_mul_last = (r_state == MUL_RUN) && (r_cnt == c_cnt_last);
  assign w_mul_done = w_mul_last && w_out_free;
  assign w_mul_step = (r_state == MUL_RUN) && (!w_mul_last || w_out_free);
  assign w_acc_step = r_acc + (r_b_sh[0] ? r_a_sh : {(2*WIDTH){1'b0}});

  assign w_b_eff = (bus.op == c_op_sub) ? ~bus.b : bus.b;
  assign w_sum   = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, bus.cin};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.op)
      c_op_add, c_op_sub: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      c_op_and:  w_res = bus.a & bus.b;
      c_op_or:   w_res = bus.a | bus.b;
      c_op_xor:  w_res = bus.a ^ bus.b;
      c_op_nota: w_res = ~bus.a;
      c_op_shl: begin
        w_res   = {bus.a[WIDTH-2:0], 1'b0};
        w_carry = bus.a[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept_mul) w_state_nxt = MUL_RUN;
      MUL_RUN: if (w_mul_done)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
    end else if (w_accept_mul) begin
      r_cnt  <= '0;
      r_a_sh <= {{WIDTH{1'b0}}, bus.a};
      r_b_sh <= bus.b;
      r_acc  <= '0;
    end else if (w_mul_step) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_acc  <= w_acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
    end else if (w_accept && !w_accept_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_result_hi <= '0;
      r_carry_out <= w_carry;
      r_overflow  <= w_ovf;
      r_zero      <= (w_res == '0);
      r_negative  <= w_res[WIDTH-1];
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_acc_step[WIDTH-1:0];
      r_result_hi <= w_acc_step[2*WIDTH-1:WIDTH];
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= (w_acc_step == '0);
      r_negative  <= w_acc_step[2*WIDTH-1];
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;

endmodule

`default_nettype wire
